core_load_scheduler: RTL and testbench

- Sequences loading of the per-core input stream.
- Round-robin arbitrates among per-core load requests and drives the one-hot core-select (access_core) into the core-side stream scanner.
- Monitors the chip-side stream handshake to detect frame completion, length errors and stalls, then acknowledges the requester.
- Sits beside the inbound sync FIFO/scanner pair, fed by the host-side request register bank.

---
 rtl/core_load_scheduler.sv | 148 ++++++++++++++
 tb/tb_core_load_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_load_scheduler.sv
// Round-robin load scheduler: grants one core at a time, drives its one-hot select into the
// stream scanner, and watches the stream handshake for frame end, length errors and stalls.
module core_load_scheduler #(
  parameter int unsigned M_COUNT        = 8,
  parameter int unsigned EXPECTED_BEATS = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned IDX_W          = $clog2(M_COUNT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               flush,
  input  logic [M_COUNT-1:0] req,
  input  logic               mon_valid,
  input  logic               mon_ready,
  input  logic               mon_last,
  output logic [M_COUNT-1:0] access_core,
  output logic               busy,
  output logic [M_COUNT-1:0] ack,
  output logic               done,
  output logic [IDX_W-1:0]   done_idx,
  output logic               len_err,
  output logic               timeout_err
);

  localparam int unsigned BEAT_W = $clog2(EXPECTED_BEATS + 1) + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StArb, StLoad, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   arb_idx, cand;
  logic               arb_found;
  logic [M_COUNT-1:0] access_q, access_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [BEAT_W:0]    beat_cnt_inc;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic               len_err_q, len_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic               beat;

  assign beat         = mon_valid & mon_ready;
  assign beat_cnt_inc = {1'b0, beat_cnt_q} + (BEAT_W + 1)'(1);

  // First requester strictly after the last grant, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_q;
    cand      = rr_q;
    for (int unsigned i = 1; i <= M_COUNT; i++) begin
      cand = IDX_W'((32'(rr_q) + i) % M_COUNT);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    access_d      = access_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    len_err_d     = len_err_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StIdle: begin
        if (enable && (|req)) state_d = StArb;
      end
      StArb: begin
        beat_cnt_d    = '0;
        idle_cnt_d    = '0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        if (flush || !arb_found) begin
          state_d = StIdle;
        end else begin
          grant_d  = arb_idx;
          rr_d     = arb_idx;
          access_d = M_COUNT'(1) << arb_idx;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (flush) begin
          access_d = '0;
          state_d  = StIdle;
        end else if (beat) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          idle_cnt_d = '0;
          if (mon_last) begin
            len_err_d     = (beat_cnt_inc != (BEAT_W + 1)'(EXPECTED_BEATS));
            timeout_err_d = 1'b0;
            access_d      = '0;
            state_d       = StDone;
          end
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 2)) begin
          // This beatless cycle brings the idle count to TIMEOUT_CYCLES-1.
          len_err_d     = 1'b0;
          timeout_err_d = 1'b1;
          access_d      = '0;
          state_d       = StDone;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_q          <= IDX_W'(M_COUNT - 1);
      grant_q       <= '0;
      access_q      <= '0;
      beat_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      access_q      <= access_d;
      beat_cnt_q    <= beat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign access_core = access_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign ack         = done ? (M_COUNT'(1) << grant_q) : '0;
  assign done_idx    = done ? grant_q : '0;
  assign len_err     = done & len_err_q;
  assign timeout_err = done & timeout_err_q;

endmodule

// File: tb/tb_core_load_scheduler.sv
// Randomized bench for core_load_scheduler, checked against a frame-level model of
// round-robin grant order, handshake counting and stall timeout.
module tb_core_load_scheduler;

  localparam int M  = 8;
  localparam int EB = 64;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset, enable, flush;
  logic [M-1:0] req;
  logic         mon_valid, mon_ready, mon_last;
  logic [M-1:0] access_core, ack;
  logic         busy, done;
  logic [2:0]   done_idx;
  logic         len_err, timeout_err;

  int checks = 0;
  int errors = 0;
  int rr_m;

  core_load_scheduler #(
    .M_COUNT        (M),
    .EXPECTED_BEATS (EB),
    .TIMEOUT_CYCLES (TO),
    .IDX_W          (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .req         (req),
    .mon_valid   (mon_valid),
    .mon_ready   (mon_ready),
    .mon_last    (mon_last),
    .access_core (access_core),
    .busy        (busy),
    .ack         (ack),
    .done        (done),
    .done_idx    (done_idx),
    .len_err     (len_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_grant(input int rr, input logic [M-1:0] r);
    for (int k = 1; k <= M; k++) begin
      int c;
      c = (rr + k) % M;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [M-1:0] onehot(input int g);
    logic [M-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [22:0] outs();
    return {busy, access_core, done, ack, done_idx, len_err, timeout_err};
  endfunction

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; flush = 1'b0; req = '0;
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    step();
    rr_m = M - 1;
    checks++;
    if (outs() !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 000000", outs());
    end
    reset = 1'b0;
  endtask

  // Called in an IDLE cycle; checks the ARB cycle and the first LOAD cycle.
  task automatic start_grant(input logic [M-1:0] r, output int g);
    req = r;
    enable = 1'b1;
    g = next_grant(rr_m, r);
    step();
    checks++;
    if (busy !== 1'b1 || access_core !== '0) begin
      errors++;
      $display("FAIL arb_cycle: got busy=%b access=%h want busy=1 access=00", busy, access_core);
    end
    step();
    checks++;
    if (access_core !== onehot(g)) begin
      errors++;
      $display("FAIL grant_access: got %h want %h (req %h)", access_core, onehot(g), r);
    end
    rr_m = g;
  endtask

  // Drives one frame from the first LOAD cycle and predicts the end of it.
  task automatic run_load(input string name, input int g, input int n_last, input int n_stop,
                          input int pause, input int flush_beat, input bit gap,
                          input bit drop_en);
    int cnt = 0;
    int idle_run = 0;
    bit extra = 1'b0;
    bit fin = 1'b0;
    bit got_done = 1'b0;
    bit v, r, l, hs, f, e_len, e_to;
    logic [22:0] want;
    for (int j = 0; j < 3000 && !fin; j++) begin
      if (cnt < n_stop) begin
        if (gap && idle_run < 8) begin
          v = 1'($urandom % 2);
          r = 1'($urandom % 2);
        end else begin
          v = 1'b1;
          r = 1'b1;
        end
      end else if (pause > 0 && !extra && idle_run == pause) begin
        v = 1'b1;
        r = 1'b1;
        extra = 1'b1;
      end else begin
        v = 1'b0;
        r = 1'($urandom % 2);
      end
      hs = v && r;
      l  = hs ? (cnt + 1 == n_last) : 1'($urandom % 2);
      f  = hs && (cnt + 1 == flush_beat);
      if (drop_en && j == 3) enable = 1'b0;
      mon_valid = v; mon_ready = r; mon_last = l; flush = f;
      step();
      flush = 1'b0;
      if (hs) begin
        cnt++;
        idle_run = 0;
      end else begin
        idle_run++;
      end
      e_len = 1'b0;
      e_to  = 1'b0;
      want  = {1'b1, onehot(g), 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      if (f) begin
        want = 23'h0;
        fin  = 1'b1;
      end else if (hs && l) begin
        e_len = (cnt != EB);
        fin   = 1'b1;
      end else if (!hs && idle_run == TO - 1) begin
        e_to = 1'b1;
        fin  = 1'b1;
      end
      if (fin && !f) begin
        want = {1'b1, 8'h00, 1'b1, onehot(g), 3'(g), e_len, e_to};
        got_done = 1'b1;
      end
      checks++;
      if (outs() !== want) begin
        errors++;
        $display("FAIL %s cycle %0d beats %0d: got %h want %h", name, j, cnt, outs(), want);
      end
    end
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    if (!fin) begin
      errors++;
      $display("FAIL %s bound: frame never ended, got beats %0d want end", name, cnt);
    end
    if (got_done) begin
      step();
      checks++;
      if (outs() !== 23'h0) begin
        errors++;
        $display("FAIL %s after_done: got %h want 000000", name, outs());
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    req = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_enable: got busy=%b want 0", busy);
      end
    end
    enable = 1'b1;
    req = '0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_core();
    int g;
    do_reset();
    start_grant(8'h04, g);
    run_load("single_core", g, 64, 1000, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      start_grant(8'h81, g);
      run_load("rr_81", g, 64, 1000, 0, 0, 1'b1, 1'b0);
    end
    start_grant(8'hFF, g);
    run_load("rr_ff", g, 64, 1000, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_len_err();
    int g;
    do_reset();
    start_grant(8'h10, g);
    run_load("len_short", g, 10, 1000, 0, 0, 1'b0, 1'b0);
    start_grant(8'h10, g);
    run_load("len_long", g, 70, 1000, 0, 0, 1'b0, 1'b0);
    start_grant(8'h10, g);
    run_load("len_gapped", g, 64, 1000, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int g;
    do_reset();
    start_grant(8'h08, g);
    run_load("timeout", g, 0, 5, 0, 0, 1'b0, 1'b0);
    start_grant(8'h08, g);
    run_load("timeout_restart", g, 0, 5, TO - 2, 0, 1'b0, 1'b0);
    start_grant(8'h08, g);
    run_load("timeout_no_beats", g, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_enable();
    int g;
    do_reset();
    start_grant(8'hFF, g);
    run_load("flush_mid", g, 64, 1000, 0, 3, 1'b0, 1'b0);
    start_grant(8'hFF, g);
    run_load("flush_last", g, 20, 1000, 0, 20, 1'b1, 1'b0);
    start_grant(8'hFF, g);
    run_load("enable_drop", g, 64, 1000, 0, 0, 1'b1, 1'b1);
    start_grant(8'hFF, g);
    run_load("after_enable_drop", g, 64, 1000, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_load();
    int g;
    do_reset();
    start_grant(8'h20, g);
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rr_m = M - 1;
    checks++;
    if (outs() !== 23'h0) begin
      errors++;
      $display("FAIL reset_mid_load: got %h want 000000", outs());
    end
    req = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || access_core !== '0) begin
        errors++;
        $display("FAIL idle_beats: got busy=%b access=%h want 0/00", busy, access_core);
      end
    end
    start_grant(8'h24, g);
    run_load("post_reset_frame", g, 64, 1000, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int g, mode, n_last, n_stop, fb;
    logic [M-1:0] r;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      r = M'($urandom);
      if (r == '0) r = 8'h01;
      mode   = $urandom % 6;
      n_last = $urandom_range(1, 80);
      n_stop = 1000;
      fb     = 0;
      if (mode == 0) fb = $urandom_range(1, n_last);
      if (mode == 1) begin
        n_last = 0;
        n_stop = $urandom_range(0, 10);
      end
      start_grant(r, g);
      run_load("random", g, n_last, n_stop, 0, fb, 1'($urandom % 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_round_robin();
    test_len_err();
    test_timeout();
    test_flush_enable();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
